// File: rtl/ahb_slave_mem.sv
// AHB-Lite data-memory slave: byte-lane writes, wait-stated reads, two-cycle ERROR response.
// Define AHB_SLV_MISALIGN_ERR_EN to reject misaligned half/word accesses instead of aligning them down.
module ahb_slave_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [7:0]  BASE_HI     = 8'hB0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_STATES);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    lanes_q, lanes_d;
  logic          write_q, write_d;
  logic          hreadyout_q, hreadyout_d;
  logic          hresp_q, hresp_d;
  logic [31:0]   hrdata_q, hrdata_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          accept_s, legal_s, wr_en_s;
  logic [AW-1:0] rd_idx_s;
  logic [31:0]   wr_word_s, rd_word_s;
  logic          unused_s;

  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size)
      3'b000:  m = 4'b0001 << a;
      3'b001:  m = a[1] ? 4'b1100 : 4'b0011;
      3'b010:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] mask);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

  assign unused_s = ^{htrans[0], hprot};

  // Address-phase decode and legality
  always_comb begin
    accept_s = hsel & hready & htrans[1];
    legal_s  = (haddr[31:24] == BASE_HI) && ({10'd0, haddr[23:2]} < 32'(DEPTH_WORDS)) &&
               (hsize <= 3'b010);
`ifdef AHB_SLV_MISALIGN_ERR_EN
    if ((hsize == 3'b001 && haddr[0]) || (hsize == 3'b010 && haddr[1:0] != 2'b00)) begin
      legal_s = 1'b0;
    end else begin
      legal_s = legal_s;
    end
`endif
  end

  // Write commit on the DATA edge; a read entering DATA on that same edge sees the merged word
  always_comb begin
    wr_en_s   = (state_q == ST_DATA) && write_q;
    wr_word_s = lane_merge(mem_q[idx_q], hwdata, lanes_q);
    rd_idx_s  = (state_q == ST_WAIT) ? idx_q : haddr[AW+1:2];
    if (wr_en_s && (rd_idx_s == idx_q)) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = mem_q[rd_idx_s];
    end
  end

  // Transfer state machine and pending-transfer registers
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    write_d = write_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          idx_d   = haddr[AW+1:2];
          lanes_d = lane_mask(hsize, haddr[1:0]);
          write_d = hwrite;
          if (!legal_s) begin
            state_d = ST_ERR1;
          end else if (WAIT_CNT == 4'd0) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_CNT;
          end
        end else begin
          state_d = ST_IDLE;
          write_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    if ((state_d == ST_DATA) && !write_d) begin
      hrdata_d = rd_word_s;
    end else begin
      hrdata_d = hrdata_q;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      lanes_q     <= 4'd0;
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      hrdata_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      lanes_q     <= lanes_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[idx_q] <= wr_word_s;
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: transaction-level model with a per-cycle compare process.
module tb_ahb_slave_mem;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'b010;
  logic [3:0]  hprot = 4'b0011;
  logic [31:0] hwdata = 32'h0;
  logic        hreadyout, hresp;
  logic [31:0] hrdata;

  typedef struct packed {
    logic        rdy;
    logic        resp;
    logic        rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e;
  logic [31:0] mem_m [int];
  logic [31:0] pend_wd = 32'h0;
  logic [31:0] last_rd = 32'h0;
  logic [31:0] rd_seen = 32'h0;
  logic        chk_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  ahb_slave_mem #(.DEPTH_WORDS(1024), .BASE_HI(8'hB0), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset_n(reset_n), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hready(hreadyout),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit legal_m(input logic [31:0] a, input logic [2:0] sz);
    bit ok;
    ok = (a[31:24] == 8'hB0) && (a[23:2] < 22'd1024) && (sz <= 3'd2);
`ifdef AHB_SLV_MISALIGN_ERR_EN
    if (ok && ((a & ((32'd1 << sz) - 32'd1)) != 32'd0)) ok = 1'b0;
`endif
    return ok;
  endfunction

  // Present one address phase, wait for it to be accepted, and queue its expected data phase
  task automatic do_txn(input logic sel, input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
    int g;
    int idx;
    int n;
    int lo;
    logic [31:0] al;
    logic [31:0] w;
    hsel = sel; htrans = tr; hwrite = wr; hsize = sz; haddr = a;
    hwdata = pend_wd;
    pend_wd = wd;
    g = 0;
    while (!hreadyout && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) chk("hready_timeout", 32'(hreadyout), 32'd1);
    if (sel && tr[1]) begin
      if (!legal_m(a, sz)) begin
        exp_q.push_back({1'b0, 1'b1, 1'b0, 32'h0});
        exp_q.push_back({1'b1, 1'b1, 1'b0, 32'h0});
      end else begin
        idx = int'(a[23:2]);
        n   = 1 << sz;
        al  = a & ~(32'(n) - 32'd1);
        lo  = int'(al[1:0]);
        for (int i = 0; i < WS; i++) exp_q.push_back({1'b0, 1'b0, 1'b0, 32'h0});
        if (wr) begin
          w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
          for (int b = 0; b < 4; b++) begin
            if (b >= lo && b < lo + n) w[8*b +: 8] = wd[8*b +: 8];
          end
          mem_m[idx] = w;
          exp_q.push_back({1'b1, 1'b0, 1'b0, 32'h0});
        end else begin
          exp_q.push_back({1'b1, 1'b0, 1'b1, mem_m[idx]});
        end
      end
    end else begin
      exp_q.push_back({1'b1, 1'b0, 1'b0, 32'h0});
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    do_txn(1'b1, 2'b10, 1'b1, sz, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    do_txn(1'b1, 2'b10, 1'b0, 3'b010, a, 32'h0);
  endtask

  task automatic drain();
    int g;
    do_txn(1'b0, 2'b00, 1'b0, 3'b010, 32'h0, 32'h0);
    g = 0;
    while (exp_q.size() != 0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (g >= 40) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Per-cycle comparison of outputs against the model queue
  always begin
    @(posedge clk);
    #1;
    if (chk_en && reset_n) begin
      if (exp_q.size() > 0) cur_e = exp_q.pop_front();
      else cur_e = {1'b1, 1'b0, 1'b0, 32'h0};
      chk("hreadyout", 32'(hreadyout), 32'(cur_e.rdy));
      chk("hresp", 32'(hresp), 32'(cur_e.resp));
      if (cur_e.rd) begin
        chk("hrdata", hrdata, cur_e.data);
        last_rd = cur_e.data;
        rd_seen = hrdata;
      end else begin
        chk("hrdata_hold", hrdata, last_rd);
      end
    end
  end

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // word write then read, two wait states each
    rd_seen = 32'h0;
    wr(3'b010, 32'hB000_0010, 32'hDEAD_BEEF);
    rd(32'hB000_0010);
    drain();
    chk("word_rd", rd_seen, 32'hDEAD_BEEF);

    // reset during the WAIT of a write to the same word
    chk_en = 1'b0;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010; haddr = 32'hB000_0010;
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678;
    @(negedge clk);
    chk("mid_wait_low", 32'(hreadyout), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("rst2_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst2_hresp", 32'(hresp), 32'd0);
    chk("rst2_hrdata", hrdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    last_rd = 32'h0;
    pend_wd = 32'h0;
    chk_en = 1'b1;
    @(negedge clk);
    rd_seen = 32'h0;
    rd(32'hB000_0010);
    drain();
    chk("no_partial_wr", rd_seen, 32'hDEAD_BEEF);

    // byte and halfword lanes
    rd_seen = 32'h0;
    wr(3'b010, 32'hB000_0010, 32'h1122_3344);
    wr(3'b000, 32'hB000_0012, 32'h00AA_0000);
    rd(32'hB000_0010);
    drain();
    chk("byte_lane2", rd_seen, 32'h11AA_3344);
    rd_seen = 32'h0;
    wr(3'b001, 32'hB000_0012, 32'hBEEF_0000);
    rd(32'hB000_0010);
    drain();
    chk("half_upper", rd_seen, 32'hBEEF_3344);
    rd_seen = 32'h0;
    wr(3'b010, 32'hB000_0020, 32'h0000_0000);
    wr(3'b000, 32'hB000_0021, 32'h0000_5500);
    rd(32'hB000_0020);
    drain();
    chk("byte_lane1", rd_seen, 32'h0000_5500);

    // illegal accesses, BUSY and deselected phases leave memory untouched
    rd_seen = 32'h0;
    rd(32'hA000_0000);
    rd(32'hB000_1000);
    wr(3'b011, 32'hB000_0010, 32'hFFFF_FFFF);
    wr(3'b010, 32'hA000_0010, 32'hFFFF_FFFF);
    do_txn(1'b1, 2'b01, 1'b1, 3'b010, 32'hB000_0010, 32'hFFFF_FFFF);
    do_txn(1'b0, 2'b10, 1'b1, 3'b010, 32'hB000_0010, 32'hFFFF_FFFF);
    rd(32'hB000_0010);
    drain();
    chk("mem_after_err", rd_seen, 32'hBEEF_3344);

    // back-to-back write/read of one word
    rd_seen = 32'h0;
    wr(3'b010, 32'hB000_0000, 32'hCAFE_F00D);
    rd(32'hB000_0000);
    drain();
    chk("raw_b2b", rd_seen, 32'hCAFE_F00D);

    // misaligned word read and half write
    rd_seen = 32'h0;
    wr(3'b010, 32'hB000_0004, 32'h0BAD_C0DE);
    rd(32'hB000_0006);
    drain();
`ifndef AHB_SLV_MISALIGN_ERR_EN
    chk("misalign_rd", rd_seen, 32'h0BAD_C0DE);
`endif
    rd_seen = 32'h0;
    wr(3'b001, 32'hB000_0005, 32'h0000_7777);
    rd(32'hB000_0004);
    drain();
`ifdef AHB_SLV_MISALIGN_ERR_EN
    chk("misalign_wr", rd_seen, 32'h0BAD_C0DE);
`else
    chk("misalign_wr", rd_seen, 32'h0BAD_7777);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
